cpu_ctrl: RTL and testbench

Multi-cycle control unit for the single-issue MIPS-subset core. It fetches instructions, reads the 32×32 register file and drives the combinational ALU's operand/instruction inputs. It then samples the ALU's result and flags and performs memory access, register writeback and PC update. It sits between the instruction/data memory ports and the ALU, on the opposite side of the ALU's `regA/regB/instruction → RESULT/FLAGS` interface.

---
 rtl/cpu_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit for the MIPS-subset core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB around an external
// combinational ALU and owns the 32x32 register file and the PC.
// Optional feature macro: CPU_CTRL_OVF_TRAP_EN (signed overflow on
// add/sub/addi traps to HALT with exc set instead of writing back).
module cpu_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_valid_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_valid_i,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic [31:0] alu_instr_o,
   input  logic [31:0] alu_result_i,
   input  logic [2:0]  alu_flags_i,
   output logic        halt_o,
   output logic        exc_o,
   output logic [31:0] pc_o
);

   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StHalt   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        imem_req_q, imem_req_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [31:0] alu_instr_q, alu_instr_d;
   logic [31:0] res_q, res_d;
   logic        br_q, br_d;
   logic        halt_q, halt_d;

   logic [31:0] rf_q [32];
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val, br_off;
   logic        dec_valid, dec_rtype, dec_slt, dec_branch;
   logic        dec_load, dec_store, dec_wr, dec_ovf;
   logic        trap;

   assign opcode = instr_q[31:26];
   assign rs     = instr_q[25:21];
   assign rt     = instr_q[20:16];
   assign rd     = instr_q[15:11];
   assign funct  = instr_q[5:0];
   assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // r0 is hard-wired to zero on the read side
   assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   // Decode the captured instruction; it stays in instr_q until the next fetch
   always_comb begin
      dec_valid  = 1'b0;
      dec_rtype  = 1'b0;
      dec_slt    = 1'b0;
      dec_branch = 1'b0;
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_wr     = 1'b0;
      dec_ovf    = 1'b0;
      case (opcode)
         6'h00: begin
            dec_rtype = 1'b1;
            case (funct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: dec_valid = 1'b1;
               6'h20, 6'h22: begin
                  dec_valid = 1'b1;
                  dec_ovf   = 1'b1;
               end
               6'h2a, 6'h2b: begin
                  dec_valid = 1'b1;
                  dec_slt   = 1'b1;
               end
               default: dec_valid = 1'b0;
            endcase
            dec_wr = dec_valid;
         end
         6'h08: begin
            dec_valid = 1'b1;
            dec_wr    = 1'b1;
            dec_ovf   = 1'b1;
         end
         6'h09: begin
            dec_valid = 1'b1;
            dec_wr    = 1'b1;
         end
         6'h0a, 6'h0b: begin
            dec_valid = 1'b1;
            dec_wr    = 1'b1;
            dec_slt   = 1'b1;
         end
         6'h04, 6'h05: begin
            dec_valid  = 1'b1;
            dec_branch = 1'b1;
         end
         6'h23: begin
            dec_valid = 1'b1;
            dec_wr    = 1'b1;
            dec_load  = 1'b1;
         end
         6'h2b: begin
            dec_valid = 1'b1;
            dec_store = 1'b1;
         end
         default: dec_valid = 1'b0;
      endcase
   end

`ifdef CPU_CTRL_OVF_TRAP_EN
   logic exc_q, exc_d;
   assign trap  = dec_ovf & alu_flags_i[2];
   assign exc_o = exc_q;
`else
   logic unused_ovf;
   assign unused_ovf = dec_ovf ^ alu_flags_i[2];
   assign trap       = 1'b0;
   assign exc_o      = 1'b0;
`endif

   assign rf_waddr = dec_rtype ? rd : rt;
   assign rf_wdata = res_q;

   // Next-state logic for the sequencer and all registered outputs
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_instr_d  = alu_instr_q;
      res_d        = res_q;
      br_d         = br_q;
      halt_d       = halt_q;
`ifdef CPU_CTRL_OVF_TRAP_EN
      exc_d        = exc_q;
`endif
      rf_we        = 1'b0;
      case (state_q)
         StFetch: begin
            if (!imem_req_q) begin
               // only reached straight after reset release
               imem_req_d = 1'b1;
            end else if (imem_valid_i) begin
               instr_d    = imem_rdata_i;
               imem_req_d = 1'b0;
               state_d    = StDecode;
            end
         end
         StDecode: begin
            if (!dec_valid) begin
               halt_d  = 1'b1;
               state_d = StHalt;
            end else begin
               alu_a_d     = rs_val;
               alu_b_d     = rt_val;
               alu_instr_d = instr_q;
               state_d     = StExec;
            end
         end
         StExec: begin
            res_d = dec_slt ? {31'd0, alu_flags_i[1]} : alu_result_i;
            br_d  = alu_flags_i[0];
            if (trap) begin
               // PC stays on the faulting instruction
               halt_d  = 1'b1;
`ifdef CPU_CTRL_OVF_TRAP_EN
               exc_d   = 1'b1;
`endif
               state_d = StHalt;
            end else if (dec_load || dec_store) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = dec_store;
               dmem_addr_d  = alu_result_i;
               dmem_wdata_d = alu_b_q;
               state_d      = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (dmem_valid_i) begin
               if (!dmem_we_q) res_d = dmem_rdata_i;
               dmem_req_d   = 1'b0;
               dmem_we_d    = 1'b0;
               dmem_addr_d  = 32'd0;
               dmem_wdata_d = 32'd0;
               state_d      = StWb;
            end
         end
         StWb: begin
            rf_we      = dec_wr && (rf_waddr != 5'd0);
            pc_d       = (dec_branch && br_q) ? pc_q + 32'd4 + br_off : pc_q + 32'd4;
            imem_req_d = 1'b1;
            state_d    = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            halt_d  = 1'b1;
            state_d = StHalt;
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_instr_q  <= '0;
         res_q        <= '0;
         br_q         <= 1'b0;
         halt_q       <= 1'b0;
`ifdef CPU_CTRL_OVF_TRAP_EN
         exc_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_instr_q  <= alu_instr_d;
         res_q        <= res_d;
         br_q         <= br_d;
         halt_q       <= halt_d;
`ifdef CPU_CTRL_OVF_TRAP_EN
         exc_q        <= exc_d;
`endif
      end
   end

   // Register file write port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[rf_waddr] <= rf_wdata;
      end
   end

   assign imem_req_o   = imem_req_q;
   assign imem_addr_o  = pc_q;
   assign pc_o         = pc_q;
   assign dmem_req_o   = dmem_req_q;
   assign dmem_we_o    = dmem_we_q;
   assign dmem_addr_o  = dmem_addr_q;
   assign dmem_wdata_o = dmem_wdata_q;
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_instr_o  = alu_instr_q;
   assign halt_o       = halt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: runs a directed program through cpu_ctrl with behavioural
// memories and ALU; expected fetch addresses and data accesses are queued
// up front and a negedge monitor compares them as the DUT presents them.
module tb_cpu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_valid, halt, exc;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] alu_a, alu_b, alu_instr, alu_result, pc;
   logic [2:0]  alu_flags;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          hold;
   } dacc_t;

   logic [31:0] exp_fetch [$];
   dacc_t       exp_dacc [$];

   always #5 clk = ~clk;

   cpu_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .imem_req_o  (imem_req),
      .imem_addr_o (imem_addr),
      .imem_rdata_i(imem_rdata),
      .imem_valid_i(imem_valid),
      .dmem_req_o  (dmem_req),
      .dmem_we_o   (dmem_we),
      .dmem_addr_o (dmem_addr),
      .dmem_wdata_o(dmem_wdata),
      .dmem_rdata_i(dmem_rdata),
      .dmem_valid_i(dmem_valid),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_instr_o (alu_instr),
      .alu_result_i(alu_result),
      .alu_flags_i (alu_flags),
      .halt_o      (halt),
      .exc_o       (exc),
      .pc_o        (pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Instruction memory: 2 wait states at 0x40, zero-wait elsewhere
   logic [31:0] imem_m [64];
   int icnt;
   assign imem_rdata = imem_m[imem_addr[7:2]];
   assign imem_valid = imem_req && (icnt >= ((imem_addr == 32'h40) ? 2 : 0));
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) icnt <= 0;
      else icnt <= (imem_req && !imem_valid) ? icnt + 1 : 0;
   end

   // Data memory: 3 wait states below 0x10, zero-wait elsewhere
   logic [31:0] dmem_m [64];
   int dcnt;
   assign dmem_rdata = dmem_m[dmem_addr[7:2]];
   assign dmem_valid = dmem_req && (dcnt >= ((dmem_addr < 32'h10) ? 3 : 0));
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dcnt <= 0;
      else dcnt <= (dmem_req && !dmem_valid) ? dcnt + 1 : 0;
   end
   always @(posedge clk) begin
      if (rst_n && dmem_req && dmem_we && dmem_valid) dmem_m[dmem_addr[7:2]] <= dmem_wdata;
   end

   // Behavioural ALU
   logic [5:0]  a_op, a_fn;
   logic [4:0]  a_sh;
   logic [31:0] a_imm, a_s;
   logic        a_ovf, a_lt, a_br;
   always_comb begin
      a_op  = alu_instr[31:26];
      a_fn  = alu_instr[5:0];
      a_sh  = alu_instr[10:6];
      a_imm = {{16{alu_instr[15]}}, alu_instr[15:0]};
      a_s   = 32'd0;
      a_ovf = 1'b0;
      a_lt  = 1'b0;
      a_br  = 1'b0;
      case (a_op)
         6'h00: begin
            case (a_fn)
               6'h00: a_s = alu_b << a_sh;
               6'h02: a_s = alu_b >> a_sh;
               6'h03: a_s = $signed(alu_b) >>> a_sh;
               6'h04: a_s = alu_b << alu_a[4:0];
               6'h06: a_s = alu_b >> alu_a[4:0];
               6'h07: a_s = $signed(alu_b) >>> alu_a[4:0];
               6'h20, 6'h21: begin
                  a_s   = alu_a + alu_b;
                  a_ovf = (a_fn == 6'h20) && (alu_a[31] == alu_b[31]) && (a_s[31] != alu_a[31]);
               end
               6'h22, 6'h23: begin
                  a_s   = alu_a - alu_b;
                  a_ovf = (a_fn == 6'h22) && (alu_a[31] != alu_b[31]) && (a_s[31] != alu_a[31]);
               end
               6'h24: a_s = alu_a & alu_b;
               6'h25: a_s = alu_a | alu_b;
               6'h26: a_s = alu_a ^ alu_b;
               6'h27: a_s = ~(alu_a | alu_b);
               6'h2a: a_lt = $signed(alu_a) < $signed(alu_b);
               6'h2b: a_lt = alu_a < alu_b;
               default: a_s = 32'd0;
            endcase
         end
         6'h08, 6'h09: begin
            a_s   = alu_a + a_imm;
            a_ovf = (a_op == 6'h08) && (alu_a[31] == a_imm[31]) && (a_s[31] != alu_a[31]);
         end
         6'h0a: a_lt = $signed(alu_a) < $signed(a_imm);
         6'h0b: a_lt = alu_a < a_imm;
         6'h04: begin
            a_s  = alu_a - alu_b;
            a_br = alu_a == alu_b;
         end
         6'h05: begin
            a_s  = alu_a - alu_b;
            a_br = alu_a != alu_b;
         end
         6'h23, 6'h2b: a_s = alu_a + a_imm;
         default: a_s = 32'd0;
      endcase
   end
   assign alu_result = a_s;
   assign alu_flags  = {a_ovf, a_lt, a_br};

   // Monitor: compares every fetch and data-port handshake against the queues
   logic [31:0] d_addr0, d_wd0;
   logic        d_we0;
   int          d_cnt = 0;
   bit          d_prev_hs = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req && imem_valid) begin
            if (exp_fetch.size() == 0) chk("unexpected_fetch", imem_addr, 64'hdead);
            else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
         end
         if (d_prev_hs) chk("dmem_req_drop", dmem_req, 0);
         d_prev_hs = 1'b0;
         if (dmem_req) begin
            if (d_cnt == 0) begin
               d_addr0 = dmem_addr;
               d_wd0   = dmem_wdata;
               d_we0   = dmem_we;
            end else begin
               chk("dmem_hold", {dmem_addr, dmem_wdata}, {d_addr0, d_wd0});
               chk("dmem_we_hold", dmem_we, d_we0);
            end
            d_cnt++;
            if (dmem_valid) begin
               if (exp_dacc.size() == 0) begin
                  chk("unexpected_dmem", dmem_addr, 64'hdead);
               end else begin
                  dacc_t e;
                  e = exp_dacc.pop_front();
                  chk("dmem_we", dmem_we, e.we);
                  chk("dmem_addr", dmem_addr, e.addr);
                  if (e.we) chk("dmem_wdata", dmem_wdata, e.data);
                  chk("dmem_req_cycles", d_cnt, e.hold);
               end
               d_cnt     = 0;
               d_prev_hs = 1'b1;
            end
         end else begin
            d_cnt = 0;
         end
      end else begin
         d_cnt     = 0;
         d_prev_hs = 1'b0;
      end
   end

   task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input int hold);
      dacc_t e;
      e.we   = we;
      e.addr = addr;
      e.data = data;
      e.hold = hold;
      exp_dacc.push_back(e);
   endtask

   // Expected fetch trace and data accesses for one complete program run
   task automatic push_run();
      for (int a = 0; a <= 'h28; a += 4) exp_fetch.push_back(a);
      for (int a = 'h3c; a <= 'h78; a += 4) exp_fetch.push_back(a);
      for (int a = 'h74; a <= 'h88; a += 4) exp_fetch.push_back(a);
`ifndef CPU_CTRL_OVF_TRAP_EN
      exp_fetch.push_back(32'h8c);
      exp_fetch.push_back(32'h90);
`endif
      push_d(1'b1, 32'h40, 32'd5, 1);
      push_d(1'b1, 32'h44, 32'd1, 1);
      push_d(1'b1, 32'h48, 32'd0, 1);
      push_d(1'b1, 32'h04, 32'd3, 4);
      push_d(1'b0, 32'h04, 32'd0, 4);
      push_d(1'b1, 32'h50, 32'd3, 1);
      push_d(1'b1, 32'h54, 32'd6, 1);
      push_d(1'b1, 32'h58, 32'hffff_fffc, 1);
      push_d(1'b1, 32'h5c, 32'h0000_000f, 1);
      push_d(1'b1, 32'h60, 32'd0, 1);
`ifndef CPU_CTRL_OVF_TRAP_EN
      push_d(1'b1, 32'h64, 32'hffff_fffe, 1);
`endif
   endtask

   task automatic run_to_halt();
      for (int i = 0; i < 3000 && !halt; i++) @(negedge clk);
      chk("halt_reached", halt, 1);
   endtask

   task automatic check_halted();
      int reqs;
`ifdef CPU_CTRL_OVF_TRAP_EN
      chk("halt_pc", pc, 32'h88);
      chk("exc", exc, 1);
      chk("r11_unchanged", dut.rf_q[11], 32'h55);
`else
      chk("halt_pc", pc, 32'h90);
      chk("exc", exc, 0);
`endif
      reqs = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (imem_req || dmem_req) reqs++;
      end
      chk("no_req_after_halt", reqs, 0);
      chk("fetches_left", exp_fetch.size(), 0);
      chk("dmem_left", exp_dacc.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) imem_m[i] = 32'hffff_ffff;
      imem_m['h00 >> 2] = 32'h2001_0005;  // addi r1,r0,5
      imem_m['h04 >> 2] = 32'hac01_0040;  // sw   r1,0x40(r0)
      imem_m['h08 >> 2] = 32'h2001_0007;  // addi r1,r0,7
      imem_m['h0c >> 2] = 32'h2002_0009;  // addi r2,r0,9
      imem_m['h10 >> 2] = 32'h0022_182a;  // slt  r3,r1,r2
      imem_m['h14 >> 2] = 32'hac03_0044;  // sw   r3,0x44(r0)
      imem_m['h18 >> 2] = 32'h0041_182b;  // sltu r3,r2,r1
      imem_m['h1c >> 2] = 32'hac03_0048;  // sw   r3,0x48(r0)
      imem_m['h20 >> 2] = 32'h2001_0003;  // addi r1,r0,3
      imem_m['h24 >> 2] = 32'h2002_0003;  // addi r2,r0,3
      imem_m['h28 >> 2] = 32'h1022_0004;  // beq  r1,r2,+4 -> 0x3c
      imem_m['h3c >> 2] = 32'h1422_0004;  // bne  r1,r2,+4 (not taken)
      imem_m['h40 >> 2] = 32'h0022_2021;  // addu r4,r1,r2
      imem_m['h44 >> 2] = 32'hac22_0001;  // sw   r2,1(r1)
      imem_m['h48 >> 2] = 32'h8c25_0001;  // lw   r5,1(r1)
      imem_m['h4c >> 2] = 32'hac05_0050;  // sw   r5,0x50(r0)
      imem_m['h50 >> 2] = 32'hac04_0054;  // sw   r4,0x54(r0)
      imem_m['h54 >> 2] = 32'h2006_fff0;  // addi r6,r0,-16
      imem_m['h58 >> 2] = 32'h0006_3883;  // sra  r7,r6,2
      imem_m['h5c >> 2] = 32'hac07_0058;  // sw   r7,0x58(r0)
      imem_m['h60 >> 2] = 32'h00c0_4027;  // nor  r8,r6,r0
      imem_m['h64 >> 2] = 32'hac08_005c;  // sw   r8,0x5c(r0)
      imem_m['h68 >> 2] = 32'h2000_0009;  // addi r0,r0,9
      imem_m['h6c >> 2] = 32'hac00_0060;  // sw   r0,0x60(r0)
      imem_m['h70 >> 2] = 32'h2009_0002;  // addi r9,r0,2
      imem_m['h74 >> 2] = 32'h2129_ffff;  // addi r9,r9,-1
      imem_m['h78 >> 2] = 32'h1520_fffe;  // bne  r9,r0,-2
      imem_m['h7c >> 2] = 32'h200a_ffff;  // addi r10,r0,-1
      imem_m['h80 >> 2] = 32'h000a_5042;  // srl  r10,r10,1
      imem_m['h84 >> 2] = 32'h200b_0055;  // addi r11,r0,0x55
      imem_m['h88 >> 2] = 32'h014a_5820;  // add  r11,r10,r10 (overflows)
      imem_m['h8c >> 2] = 32'hac0b_0064;  // sw   r11,0x64(r0)
      imem_m['h90 >> 2] = 32'h0800_0000;  // j    (unsupported)

      // Run 1: reset values, first-fetch timing, full program
      rst_n = 1'b0;
      push_run();
      repeat (2) @(negedge clk);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_ctl", {dmem_req, dmem_we, halt, exc}, 4'b0000);
      chk("rst_dmem_bus", {dmem_addr, dmem_wdata}, 64'h0);
      chk("rst_alu_bus", {alu_a, alu_b} | {32'h0, alu_instr}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("cycle1_imem_req", imem_req, 1);
      chk("cycle1_imem_addr", imem_addr, 32'h0);
      repeat (4) @(negedge clk);
      chk("pc_after_addi", pc, 32'h4);
      run_to_halt();
      check_halted();

      // Run 2: reset clears halt, reset mid-FETCH drops the request, rerun
      rst_n = 1'b0;
      #1;
      chk("rst_clears_halt", {halt, exc}, 2'b00);
      exp_fetch.push_back(32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_req", imem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midfetch_req_drop", imem_req, 0);
      chk("midfetch_pc", {pc, imem_addr}, 64'h0);
      repeat (2) @(negedge clk);
      push_run();
      rst_n = 1'b1;
      run_to_halt();
      check_halted();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
